// File: rtl/airlock_pkg.sv
// Shared types for the airlock controller: chamber state encoding and
// command-vector bit positions used by the arbiter.
package airlock_pkg;

  typedef enum logic [1:0] {
    ST_EVACUATED   = 2'd0,
    ST_FILLING     = 2'd1,
    ST_PRESSURIZED = 2'd2,
    ST_EVACUATING  = 2'd3
  } chamber_e;

  localparam int unsigned CMD_OUTER = 0;
  localparam int unsigned CMD_INNER = 1;
  localparam int unsigned CMD_FILL  = 2;
  localparam int unsigned CMD_EVAC  = 3;
  localparam int unsigned CMD_W     = 4;

  typedef logic [CMD_W-1:0] cmd_t;

  // More than one command bit set in the same cycle.
  function automatic logic multi_cmd(input cmd_t c);
    return (c & (c - cmd_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/tick_countdown.sv
// Loadable down-counter advanced by a tick enable; expire pulses combinationally
// on the tick that takes the count from 1 to 0. Priority: clear > load > tick.
module tick_countdown #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_value_i,
  input  logic             tick_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d  = count_q;
    expire_o = 1'b0;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_value_i;
    end else if (tick_i && count_q != '0) begin
      count_d  = count_q - CNT_W'(1);
      expire_o = (count_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/airlock_controller.sv
// Single-chamber airlock interlock: arbitrates door toggles and pump commands
// through one FSM, with an independent arrival/departure notice timer.
module airlock_controller
  import airlock_pkg::*;
#(
  parameter int unsigned CNT_W        = 10,
  parameter int unsigned FILL_TICKS   = 7,
  parameter int unsigned EVAC_TICKS   = 8,
  parameter int unsigned NOTIFY_TICKS = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             tick,
  input  logic             arrive_sw,
  input  logic             depart_sw,
  input  logic             outer_cmd,
  input  logic             inner_cmd,
  input  logic             fill_req,
  input  logic             evac_req,
  input  logic             abort,
  output logic             outer_closed,
  output logic             inner_closed,
  output logic             pressurized,
  output logic             evacuated,
  output logic             busy,
  output logic [CNT_W-1:0] pump_count,
  output logic             arrive_led,
  output logic             depart_led,
  output logic [CNT_W-1:0] notify_count,
  output logic             done,
  output logic             reject
);

  chamber_e state_q, state_d;
  logic outer_closed_q, outer_closed_d;
  logic inner_closed_q, inner_closed_d;
  logic arrive_led_q, arrive_led_d;
  logic depart_led_q, depart_led_d;
  logic done_q, done_d;
  logic reject_q, reject_d;
  // primed_q masks edges on the first cycle after reset so the registered
  // levels start from whatever the switches already read.
  logic primed_q;
  logic outer_lvl_q, inner_lvl_q, arrive_lvl_q, depart_lvl_q;

  logic outer_tog, inner_tog, arr_rise, dep_rise;
  cmd_t cmd;
  logic busy_w, notice_active;
  logic pump_load, pump_clear, pump_expire;
  logic [CNT_W-1:0] pump_load_val;
  logic notice_load, notice_expire;

  assign outer_tog = primed_q & (outer_cmd ^ outer_lvl_q);
  assign inner_tog = primed_q & (inner_cmd ^ inner_lvl_q);
  assign arr_rise  = primed_q & arrive_sw & ~arrive_lvl_q;
  assign dep_rise  = primed_q & depart_sw & ~depart_lvl_q;

  always_comb begin
    cmd            = '0;
    cmd[CMD_OUTER] = outer_tog;
    cmd[CMD_INNER] = inner_tog;
    cmd[CMD_FILL]  = fill_req;
    cmd[CMD_EVAC]  = evac_req;
  end

  assign busy_w        = (state_q == ST_FILLING) || (state_q == ST_EVACUATING);
  assign notice_active = arrive_led_q | depart_led_q;

  always_comb begin
    state_d        = state_q;
    outer_closed_d = outer_closed_q;
    inner_closed_d = inner_closed_q;
    arrive_led_d   = arrive_led_q;
    depart_led_d   = depart_led_q;
    done_d         = 1'b0;
    reject_d       = 1'b0;
    pump_load      = 1'b0;
    pump_load_val  = '0;
    pump_clear     = 1'b0;
    notice_load    = 1'b0;

    // An effective abort swallows the tick and every command of that cycle.
    if (abort && busy_w) begin
      pump_clear = 1'b1;
      state_d    = (state_q == ST_FILLING) ? ST_EVACUATED : ST_PRESSURIZED;
    end else begin
      if (pump_expire) begin
        state_d = (state_q == ST_FILLING) ? ST_PRESSURIZED : ST_EVACUATED;
        done_d  = 1'b1;
      end
      if (multi_cmd(cmd)) begin
        reject_d = 1'b1;
      end else if (cmd[CMD_OUTER]) begin
        if (state_q == ST_EVACUATED) outer_closed_d = ~outer_closed_q;
        else                         reject_d = 1'b1;
      end else if (cmd[CMD_INNER]) begin
        if (state_q == ST_PRESSURIZED) inner_closed_d = ~inner_closed_q;
        else                           reject_d = 1'b1;
      end else if (cmd[CMD_FILL]) begin
        if (state_q == ST_EVACUATED && outer_closed_q && inner_closed_q) begin
          state_d       = ST_FILLING;
          pump_load     = 1'b1;
          pump_load_val = CNT_W'(FILL_TICKS);
        end else begin
          reject_d = 1'b1;
        end
      end else if (cmd[CMD_EVAC]) begin
        if (state_q == ST_PRESSURIZED && outer_closed_q && inner_closed_q) begin
          state_d       = ST_EVACUATING;
          pump_load     = 1'b1;
          pump_load_val = CNT_W'(EVAC_TICKS);
        end else begin
          reject_d = 1'b1;
        end
      end
    end

    if (arr_rise || dep_rise) begin
      if (notice_active || (arr_rise && dep_rise)) begin
        reject_d = 1'b1;
      end else begin
        notice_load  = 1'b1;
        arrive_led_d = arr_rise;
        depart_led_d = dep_rise;
      end
    end
    if (notice_expire) begin
      arrive_led_d = 1'b0;
      depart_led_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q        <= ST_EVACUATED;
      outer_closed_q <= 1'b1;
      inner_closed_q <= 1'b1;
      arrive_led_q   <= 1'b0;
      depart_led_q   <= 1'b0;
      done_q         <= 1'b0;
      reject_q       <= 1'b0;
      primed_q       <= 1'b0;
      outer_lvl_q    <= 1'b0;
      inner_lvl_q    <= 1'b0;
      arrive_lvl_q   <= 1'b0;
      depart_lvl_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      outer_closed_q <= outer_closed_d;
      inner_closed_q <= inner_closed_d;
      arrive_led_q   <= arrive_led_d;
      depart_led_q   <= depart_led_d;
      done_q         <= done_d;
      reject_q       <= reject_d;
      primed_q       <= 1'b1;
      outer_lvl_q    <= outer_cmd;
      inner_lvl_q    <= inner_cmd;
      arrive_lvl_q   <= arrive_sw;
      depart_lvl_q   <= depart_sw;
    end
  end

  tick_countdown #(.CNT_W(CNT_W)) u_pump (
    .clk_i        (Clock),
    .rst_ni       (Reset),
    .load_i       (pump_load),
    .load_value_i (pump_load_val),
    .tick_i       (tick),
    .clear_i      (pump_clear),
    .count_o      (pump_count),
    .expire_o     (pump_expire)
  );

  tick_countdown #(.CNT_W(CNT_W)) u_notice (
    .clk_i        (Clock),
    .rst_ni       (Reset),
    .load_i       (notice_load),
    .load_value_i (CNT_W'(NOTIFY_TICKS)),
    .tick_i       (tick),
    .clear_i      (1'b0),
    .count_o      (notify_count),
    .expire_o     (notice_expire)
  );

  assign outer_closed = outer_closed_q;
  assign inner_closed = inner_closed_q;
  assign pressurized  = (state_q == ST_PRESSURIZED);
  assign evacuated    = (state_q == ST_EVACUATED);
  assign busy         = busy_w;
  assign arrive_led   = arrive_led_q;
  assign depart_led   = depart_led_q;
  assign done         = done_q;
  assign reject       = reject_q;

endmodule

// File: tb/tb_airlock_controller.sv
// Bench for airlock_controller: directed vector table, hand sequences for the
// notice and async-reset corners, then random traffic against a reference model.
module tb_airlock_controller;

  localparam int CNT_W = 10;
  localparam int FILL  = 7;
  localparam int EVAC  = 8;
  localparam int NOTE  = 5;

  logic Clock = 1'b0, Reset = 1'b0;
  logic tick = 0, arrive_sw = 0, depart_sw = 0, outer_cmd = 0, inner_cmd = 0;
  logic fill_req = 0, evac_req = 0, abort = 0;
  logic outer_closed, inner_closed, pressurized, evacuated, busy;
  logic arrive_led, depart_led, done, reject;
  logic [CNT_W-1:0] pump_count, notify_count;

  airlock_controller #(
    .CNT_W(CNT_W), .FILL_TICKS(FILL), .EVAC_TICKS(EVAC), .NOTIFY_TICKS(NOTE)
  ) dut (
    .Clock(Clock), .Reset(Reset), .tick(tick), .arrive_sw(arrive_sw), .depart_sw(depart_sw),
    .outer_cmd(outer_cmd), .inner_cmd(inner_cmd), .fill_req(fill_req), .evac_req(evac_req),
    .abort(abort), .outer_closed(outer_closed), .inner_closed(inner_closed),
    .pressurized(pressurized), .evacuated(evacuated), .busy(busy), .pump_count(pump_count),
    .arrive_led(arrive_led), .depart_led(depart_led), .notify_count(notify_count),
    .done(done), .reject(reject)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    bit tick, fill, evac, abort, tog_o, tog_i, tog_a, tog_d;
  } in_t;

  typedef struct packed {
    bit tick, fill, evac, tog_o, tog_i, abort;
    bit e_busy, e_press, e_oc, e_ic, e_done, e_rej;
    logic [CNT_W-1:0] e_pc;
  } vec_t;

  int n_vec = 0, n_bad = 0;

  // Reference model: resting pressure plus remaining pump ticks; a nonzero
  // pump count means a transfer toward the opposite pressure is under way.
  bit m_press, m_outer, m_inner, m_arr, m_dep, m_done, m_rej, m_primed;
  bit m_p_outer, m_p_inner, m_p_arr, m_p_dep;
  int m_pump, m_notice;

  function automatic in_t mk(bit t, bit f, bit e, bit o, bit i, bit ab, bit a, bit d);
    in_t v;
    v.tick = t; v.fill = f; v.evac = e; v.tog_o = o; v.tog_i = i;
    v.abort = ab; v.tog_a = a; v.tog_d = d;
    return v;
  endfunction

  task automatic model_reset();
    m_press = 0; m_outer = 1; m_inner = 1; m_arr = 0; m_dep = 0;
    m_done = 0; m_rej = 0; m_primed = 0; m_pump = 0; m_notice = 0;
    m_p_outer = 0; m_p_inner = 0; m_p_arr = 0; m_p_dep = 0;
  endtask

  task automatic model_step(input in_t v);
    bit ot, it, ar, dr, b0, p0, act0, ld;
    int n;
    ot = m_primed && (outer_cmd != m_p_outer);
    it = m_primed && (inner_cmd != m_p_inner);
    ar = m_primed && arrive_sw && !m_p_arr;
    dr = m_primed && depart_sw && !m_p_dep;
    m_p_outer = outer_cmd; m_p_inner = inner_cmd; m_p_arr = arrive_sw; m_p_dep = depart_sw;
    m_primed = 1;
    m_done = 0; m_rej = 0;
    b0 = (m_pump != 0); p0 = m_press; act0 = (m_notice != 0);
    n = int'(ot) + int'(it) + int'(v.fill) + int'(v.evac);
    if (v.abort && b0) begin
      m_pump = 0;
    end else begin
      if (b0 && v.tick) begin
        m_pump = m_pump - 1;
        if (m_pump == 0) begin m_press = !m_press; m_done = 1; end
      end
      if (n > 1) m_rej = 1;
      else if (ot) begin if (!b0 && !p0) m_outer = !m_outer; else m_rej = 1; end
      else if (it) begin if (!b0 && p0) m_inner = !m_inner; else m_rej = 1; end
      else if (v.fill) begin if (!b0 && !p0 && m_outer && m_inner) m_pump = FILL; else m_rej = 1; end
      else if (v.evac) begin if (!b0 && p0 && m_outer && m_inner) m_pump = EVAC; else m_rej = 1; end
    end
    ld = (ar || dr) && !act0 && !(ar && dr);
    if ((ar || dr) && !ld) m_rej = 1;
    if (ld) begin
      m_notice = NOTE; m_arr = ar; m_dep = dr;
    end else if (act0 && v.tick) begin
      m_notice = m_notice - 1;
      if (m_notice == 0) begin m_arr = 0; m_dep = 0; end
    end
  endtask

  task automatic check_model(input string name);
    logic [28:0] act, exp;
    bit bz;
    bz  = (m_pump != 0);
    act = {outer_closed, inner_closed, pressurized, evacuated, busy, arrive_led, depart_led,
           done, reject, pump_count, notify_count};
    exp = {m_outer, m_inner, !bz && m_press, !bz && !m_press, bz, m_arr, m_dep,
           m_done, m_rej, CNT_W'(m_pump), CNT_W'(m_notice)};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_val(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge: drive inputs, let one active edge pass, check at next negedge.
  task automatic apply(input in_t v, input string name);
    outer_cmd = outer_cmd ^ v.tog_o;
    inner_cmd = inner_cmd ^ v.tog_i;
    arrive_sw = arrive_sw ^ v.tog_a;
    depart_sw = depart_sw ^ v.tog_d;
    tick = v.tick; fill_req = v.fill; evac_req = v.evac; abort = v.abort;
    @(posedge Clock);
    model_step(v);
    @(negedge Clock);
    check_model(name);
  endtask

  task automatic do_reset(input string name);
    Reset = 1'b0;
    #1;
    model_reset();
    check_model(name);
    expect_val({name, "_evacuated"}, int'(evacuated), 1);
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  vec_t tbl[22];

  initial begin
    // tick fill evac tog_o tog_i abort | busy press oc ic done rej | pump_count
    tbl[0]  = '{0,1,0,1,0,0, 0,0,1,1,0,1, 10'd0};
    tbl[1]  = '{0,0,0,0,0,0, 0,0,1,1,0,0, 10'd0};
    tbl[2]  = '{0,1,0,0,0,0, 1,0,1,1,0,0, 10'd7};
    tbl[3]  = '{1,0,0,0,0,0, 1,0,1,1,0,0, 10'd6};
    tbl[4]  = '{1,0,0,0,0,0, 1,0,1,1,0,0, 10'd5};
    tbl[5]  = '{1,0,0,0,0,0, 1,0,1,1,0,0, 10'd4};
    tbl[6]  = '{1,0,0,0,0,0, 1,0,1,1,0,0, 10'd3};
    tbl[7]  = '{1,0,0,0,0,0, 1,0,1,1,0,0, 10'd2};
    tbl[8]  = '{1,0,0,0,0,0, 1,0,1,1,0,0, 10'd1};
    tbl[9]  = '{1,0,0,0,0,0, 0,1,1,1,1,0, 10'd0};
    tbl[10] = '{0,0,0,0,0,0, 0,1,1,1,0,0, 10'd0};
    tbl[11] = '{0,0,0,1,0,0, 0,1,1,1,0,1, 10'd0};
    tbl[12] = '{0,0,0,0,0,0, 0,1,1,1,0,0, 10'd0};
    tbl[13] = '{0,0,0,0,1,0, 0,1,1,0,0,0, 10'd0};
    tbl[14] = '{0,0,1,0,0,0, 0,1,1,0,0,1, 10'd0};
    tbl[15] = '{0,0,0,0,1,0, 0,1,1,1,0,0, 10'd0};
    tbl[16] = '{0,0,1,0,0,0, 1,0,1,1,0,0, 10'd8};
    tbl[17] = '{1,0,0,0,0,0, 1,0,1,1,0,0, 10'd7};
    tbl[18] = '{1,0,0,0,0,0, 1,0,1,1,0,0, 10'd6};
    tbl[19] = '{1,0,0,0,0,0, 1,0,1,1,0,0, 10'd5};
    tbl[20] = '{0,0,0,0,0,1, 0,1,1,1,0,0, 10'd0};
    tbl[21] = '{0,0,0,0,0,0, 0,1,1,1,0,0, 10'd0};

    model_reset();
    repeat (2) @(negedge Clock);
    check_model("reset_state");
    Reset = 1'b1;
    repeat (2) apply(mk(0,0,0,0,0,0,0,0), "post_reset_idle");

    foreach (tbl[i]) begin
      vec_t t;
      logic [5:0] a6, e6;
      t = tbl[i];
      apply(mk(t.tick, t.fill, t.evac, t.tog_o, t.tog_i, t.abort, 0, 0), "table_model");
      a6 = {busy, pressurized, outer_closed, inner_closed, done, reject};
      e6 = {t.e_busy, t.e_press, t.e_oc, t.e_ic, t.e_done, t.e_rej};
      n_vec++;
      if (a6 !== e6 || pump_count !== t.e_pc) begin
        n_bad++;
        $display("FAIL table[%0d]: got flags %b count %0d expected flags %b count %0d",
                 i, a6, pump_count, e6, t.e_pc);
      end
    end

    // Arrival notice counts down; a departure edge during it is refused.
    apply(mk(0,0,0,0,0,0,1,0), "arrive_rise");
    expect_val("arrive_led_on", int'(arrive_led), 1);
    expect_val("notify_loaded", int'(notify_count), NOTE);
    for (int k = 1; k <= NOTE; k++) begin
      if (k == 3) begin
        apply(mk(0,0,0,0,0,0,0,1), "depart_during_notice");
        expect_val("depart_reject", int'(reject), 1);
        expect_val("depart_led_off", int'(depart_led), 0);
      end
      apply(mk(1,0,0,0,0,0,0,0), "notice_tick");
      expect_val("notify_count", int'(notify_count), NOTE - k);
      expect_val("arrive_led_level", int'(arrive_led), (k < NOTE) ? 1 : 0);
    end
    apply(mk(0,0,0,0,0,0,1,1), "both_fall");
    apply(mk(0,0,0,0,0,0,1,1), "both_rise");
    expect_val("both_rise_reject", int'(reject), 1);
    expect_val("both_rise_no_led", int'(arrive_led | depart_led), 0);

    // Reset while evacuating with a notice running.
    apply(mk(0,0,0,0,0,0,1,1), "both_fall2");
    apply(mk(0,0,1,0,0,0,1,0), "evac_and_arrive");
    expect_val("evac_busy", int'(busy), 1);
    expect_val("evac_notice", int'(arrive_led), 1);
    repeat (2) apply(mk(1,0,0,0,0,0,0,0), "evac_tick");
    expect_val("evac_count", int'(pump_count), EVAC - 2);
    do_reset("async_reset_mid_evac");
    expect_val("reset_notice_clear", int'(notify_count), 0);
    repeat (2) apply(mk(0,0,0,0,0,0,0,0), "post_reset2");

    for (int c = 0; c < 4000; c++) begin
      in_t v;
      if ($urandom_range(599) == 0) begin
        do_reset("random_reset");
        continue;
      end
      v.tick  = ($urandom_range(2) == 0);
      v.fill  = ($urandom_range(6) == 0);
      v.evac  = ($urandom_range(6) == 0);
      v.abort = ($urandom_range(24) == 0);
      v.tog_o = ($urandom_range(9) == 0);
      v.tog_i = ($urandom_range(9) == 0);
      v.tog_a = ($urandom_range(11) == 0);
      v.tog_d = ($urandom_range(11) == 0);
      apply(v, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/airlock_controller.md
# airlock_controller

Parametrised single-chamber airlock interlock controller: one FSM owns door state, chamber pressure state and pump sequencing. It replaces the scattered per-signal toggle counters with a single arbitrated command path, adding abort, explicit rejection reporting, and configurable timer widths and durations. It sits between the synchronised and edge-detected switch/key inputs (downstream of clock divider and metastability stages) and the LED/HEX display logic.

## Interface
- CNT_W, 10: width of both countdown registers
- FILL_TICKS, 7: fill-and-pressurize duration in ticks; 1 ≤ FILL_TICKS < 2^CNT_W
- EVAC_TICKS, 8: evacuation duration in ticks; same range as FILL_TICKS
- NOTIFY_TICKS, 5: arrival/departure notice duration in ticks; same range

- Clock  in  1  system clock (divided clock domain)
- Reset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle enable, nominally 1 Hz, synchronous to Clock
- arrive_sw, depart_sw  in  1 each  synchronised levels; only rising edges are used
- outer_cmd, inner_cmd  in  1 each  synchronised levels; any edge is a toggle request
- fill_req, evac_req, abort  in  1 each  single-cycle pulses
- outer_closed, inner_closed  out  1 each  door state
- pressurized, evacuated  out  1 each  chamber state
- busy  out  1  pump sequence in progress
- pump_count  out  CNT_W  remaining fill/evac ticks; 0 when idle
- arrive_led, depart_led  out  1 each  notice active
- notify_count  out  CNT_W  remaining notice ticks
- done  out  1  one-cycle pulse when fill or evac completes
- reject  out  1  one-cycle pulse when any command is refused

## Operation
- Chamber FSM states: EVACUATED, FILLING, PRESSURIZED, EVACUATING. Reset: EVACUATED, both doors closed, pump_count 0, busy 0, done 0, reject 0.
- pressurized = (state == PRESSURIZED); evacuated = (state == EVACUATED); busy = FILLING or EVACUATING.
- Per-cycle commands: outer toggle, inner toggle, fill_req, evac_req. Priority: abort > everything. If more than one command is present, all are rejected (one reject pulse).
- Outer toggle: accepted only in EVACUATED. Inner toggle: accepted only in PRESSURIZED. Otherwise rejected; door unchanged.
- fill_req: accepted only in EVACUATED with both doors closed; goes to FILLING, pump_count ← FILL_TICKS.
- evac_req: accepted only in PRESSURIZED with both doors closed; goes to EVACUATING, pump_count ← EVAC_TICKS.
- While busy: each tick decrements pump_count. A tick with pump_count == 1 moves to the target state, sets pump_count to 0 and pulses done.
- abort: in FILLING, return to EVACUATED; in EVACUATING, return to PRESSURIZED. pump_count ← 0, no done, no reject. abort when not busy is ignored silently.
- Notice logic runs independently of the chamber FSM.
  - A rising edge on arrive_sw or depart_sw with no notice active sets the matching LED and loads notify_count ← NOTIFY_TICKS.
  - The notice counts down on ticks; the LED clears on the tick at which the count reaches 0.
  - Edge while a notice is active, or simultaneous rising edges on both: rejected.

## Timing
- Command accepted at edge N; state, doors and count update at edge N. A tick coincident with acceptance does not decrement.
- FILLING lasts exactly FILL_TICKS ticks; done is asserted in the cycle after the final tick.
- reject and done are registered and last one cycle.
- Edge detectors register their inputs; the first input-driven edge after reset deassertion is relative to the reset-sampled level, so no spurious toggles occur.
- Reset asserted mid-sequence: immediately returns to the reset values, including notice cleared.

## Structure
- airlock_pkg: chamber state enum, state encoding, command-bit positions.
- Sub-module tick_countdown (load, load_value, tick, clear, count, expire pulse), instantiated twice: pump and notice.
- Edge detection and arbitration inline in airlock_controller.

## Test plan
- Reset, then fill_req with doors closed, FILL_TICKS=7 → busy 1, pump_count 7…1, PRESSURIZED after 7 ticks, single done pulse.
- Outer toggle in PRESSURIZED → reject pulse, outer_closed stays 1; inner toggle → inner_closed 0; then evac_req → reject, since inner is open.
- evac_req, abort after 3 ticks → PRESSURIZED, pump_count 0, no done, no reject.
- fill_req and outer toggle in the same cycle → single reject pulse, nothing changes.
- arrive_sw rises → arrive_led 1, notify_count 5→0 over 5 ticks, then LED 0; depart_sw rises during the notice → reject.
- Reset asserted mid-EVACUATING → EVACUATED, doors closed, counts 0, within the same cycle (asynchronous).
